// File: rtl/vend_ctrl.sv
// Multi-product vending controller: coin credit, affordability decode, vend and change handshake.
// Defining VEND_STOCK_EN adds per-product 4-bit stock counters and the restock port.
module vend_ctrl #(
    parameter int                    CW         = 8,
    parameter int                    N_DRINK    = 4,
    parameter logic [N_DRINK*CW-1:0] PRICES     = {8'd25, 8'd20, 8'd15, 8'd10},
    parameter int                    MAX_CREDIT = 255,
    parameter int                    STOCK_INIT = 4,
    localparam int                   IW         = $clog2(N_DRINK)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               coin_valid,
    input  logic [CW-1:0]      coin_value,
    input  logic               sel_valid,
    input  logic [IW-1:0]      sel_idx,
    input  logic               cancel,
    input  logic               change_ack,
`ifdef VEND_STOCK_EN
    input  logic               restock,
    input  logic [IW-1:0]      restock_idx,
`endif
    output logic [CW-1:0]      credit,
    output logic [N_DRINK-1:0] avail,
    output logic               dispense,
    output logic [IW-1:0]      dispense_idx,
    output logic               change_valid,
    output logic [CW-1:0]      change_amt,
    output logic               coin_reject,
    output logic               sel_err,
    output logic               busy
);

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_VEND    = 2'd1,
        ST_REFUND  = 2'd2
    } state_e;

    localparam logic [CW:0] MAX_CREDIT_W = (CW+1)'(MAX_CREDIT);

    state_e               state_r;
    logic [CW-1:0]        credit_r;
    logic                 dispense_r;
    logic [IW-1:0]        dispense_idx_r;
    logic                 change_valid_r;
    logic [CW-1:0]        change_amt_r;
    logic                 coin_reject_r;
    logic                 sel_err_r;

    logic [N_DRINK-1:0]   stock_ok_s;
    logic [N_DRINK-1:0]   avail_s;
    logic                 sel_ok_s;
    logic [CW:0]          coin_sum_s;
    logic                 coin_over_s;
    logic [CW-1:0]        vend_price_s;
    logic [CW-1:0]        credit_left_s;

    function automatic logic [CW-1:0] price_of(input int i);
        return PRICES[i*CW +: CW];
    endfunction

`ifdef VEND_STOCK_EN
    logic [3:0] stock_r [N_DRINK];

    // Stock counters: restock overrides a same-cycle vend decrement of the same product.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_DRINK; i++) begin
                stock_r[i] <= 4'(STOCK_INIT);
            end
        end else begin
            for (int i = 0; i < N_DRINK; i++) begin
                if (restock && (restock_idx == IW'(i))) begin
                    stock_r[i] <= 4'(STOCK_INIT);
                end else if ((state_r == ST_VEND) && (dispense_idx_r == IW'(i)) &&
                             (stock_r[i] != 4'd0)) begin
                    stock_r[i] <= stock_r[i] - 4'd1;
                end
            end
        end
    end

    // A product with empty stock is never offered.
    always_comb begin
        stock_ok_s = '0;
        for (int i = 0; i < N_DRINK; i++) begin
            stock_ok_s[i] = (stock_r[i] != 4'd0);
        end
    end
`else
    // Without stock tracking every product is always in stock.
    always_comb begin
        stock_ok_s = {N_DRINK{1'b1}};
    end
`endif

    // Affordability decode, selection check, coin overflow and post-vend credit.
    always_comb begin
        coin_sum_s   = {1'b0, credit_r} + {1'b0, coin_value};
        coin_over_s  = (coin_sum_s > MAX_CREDIT_W);
        avail_s      = '0;
        sel_ok_s     = 1'b0;
        vend_price_s = '0;
        for (int i = 0; i < N_DRINK; i++) begin
            avail_s[i]   = (state_r == ST_COLLECT) && (credit_r >= price_of(i)) && stock_ok_s[i];
            sel_ok_s     = sel_ok_s | ((sel_idx == IW'(i)) & avail_s[i]);
            vend_price_s = vend_price_s | (price_of(i) & {CW{dispense_idx_r == IW'(i)}});
        end
        credit_left_s = credit_r - vend_price_s;
    end

    // Main controller: cancel beats select beats coin; every busy-state coin is bounced.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r        <= ST_COLLECT;
            credit_r       <= '0;
            dispense_r     <= 1'b0;
            dispense_idx_r <= '0;
            change_valid_r <= 1'b0;
            change_amt_r   <= '0;
            coin_reject_r  <= 1'b0;
            sel_err_r      <= 1'b0;
        end else begin
            dispense_r    <= 1'b0;
            coin_reject_r <= 1'b0;
            sel_err_r     <= 1'b0;
            case (state_r)
                ST_COLLECT: begin
                    if (cancel) begin
                        coin_reject_r <= coin_valid;
                        if (credit_r != '0) begin
                            state_r        <= ST_REFUND;
                            change_valid_r <= 1'b1;
                            change_amt_r   <= credit_r;
                        end
                    end else if (sel_valid) begin
                        coin_reject_r <= coin_valid;
                        if (sel_ok_s) begin
                            state_r        <= ST_VEND;
                            dispense_r     <= 1'b1;
                            dispense_idx_r <= sel_idx;
                        end else begin
                            sel_err_r <= 1'b1;
                        end
                    end else if (coin_valid) begin
                        if (coin_over_s) begin
                            coin_reject_r <= 1'b1;
                        end else begin
                            credit_r <= coin_sum_s[CW-1:0];
                        end
                    end
                end
                ST_VEND: begin
                    coin_reject_r <= coin_valid;
                    credit_r      <= credit_left_s;
                    if (credit_left_s != '0) begin
                        state_r        <= ST_REFUND;
                        change_valid_r <= 1'b1;
                        change_amt_r   <= credit_left_s;
                    end else begin
                        state_r <= ST_COLLECT;
                    end
                end
                ST_REFUND: begin
                    coin_reject_r <= coin_valid;
                    if (change_ack) begin
                        state_r        <= ST_COLLECT;
                        credit_r       <= '0;
                        change_valid_r <= 1'b0;
                        change_amt_r   <= '0;
                    end
                end
                default: begin
                    state_r        <= ST_COLLECT;
                    change_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign credit       = credit_r;
    assign avail        = avail_s;
    assign dispense     = dispense_r;
    assign dispense_idx = dispense_idx_r;
    assign change_valid = change_valid_r;
    assign change_amt   = change_amt_r;
    assign coin_reject  = coin_reject_r;
    assign sel_err      = sel_err_r;
    assign busy         = (state_r != ST_COLLECT);

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed bench for vend_ctrl: a transaction-level model is compared on every negedge,
// and hand-computed literals pin the key scenarios.
module tb_vend_ctrl;

    logic       clk;
    logic       reset;
    logic       coin_valid;
    logic [7:0] coin_value;
    logic       sel_valid;
    logic [1:0] sel_idx;
    logic       cancel;
    logic       change_ack;
    logic       restock;
    logic [1:0] restock_idx;
    logic [7:0] credit;
    logic [3:0] avail;
    logic       dispense;
    logic [1:0] dispense_idx;
    logic       change_valid;
    logic [7:0] change_amt;
    logic       coin_reject;
    logic       sel_err;
    logic       busy;

    int n_vec;
    int n_err;

`ifdef VEND_STOCK_EN
    localparam bit STOCK_EN = 1'b1;
`else
    localparam bit STOCK_EN = 1'b0;
`endif

    vend_ctrl #(.STOCK_INIT(1)) dut (
        .clk          (clk),
        .reset        (reset),
        .coin_valid   (coin_valid),
        .coin_value   (coin_value),
        .sel_valid    (sel_valid),
        .sel_idx      (sel_idx),
        .cancel       (cancel),
        .change_ack   (change_ack),
`ifdef VEND_STOCK_EN
        .restock      (restock),
        .restock_idx  (restock_idx),
`endif
        .credit       (credit),
        .avail        (avail),
        .dispense     (dispense),
        .dispense_idx (dispense_idx),
        .change_valid (change_valid),
        .change_amt   (change_amt),
        .coin_reject  (coin_reject),
        .sel_err      (sel_err),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Machine as the customer sees it: phase 0 taking coins, 1 vending, 2 paying change.
    int prices [4] = '{10, 15, 20, 25};
    int m_credit;
    int m_phase;
    int m_idx;
    int m_stock [4];
    bit e_disp, e_rej, e_err;

    function automatic logic [3:0] exp_avail();
        logic [3:0] a;
        a = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (m_phase == 0 && m_credit >= prices[i] && m_stock[i] > 0) a[i] = 1'b1;
        end
        return a;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_credit = 0; m_phase = 0; m_idx = 0;
            e_disp = 1'b0; e_rej = 1'b0; e_err = 1'b0;
            for (int i = 0; i < 4; i++) m_stock[i] = 1;
        end else begin
            e_disp = 1'b0; e_rej = 1'b0; e_err = 1'b0;
            if (m_phase == 0) begin
                if (cancel) begin
                    e_rej = coin_valid;
                    if (m_credit > 0) m_phase = 2;
                end else if (sel_valid) begin
                    e_rej = coin_valid;
                    if (exp_avail() & (4'b0001 << sel_idx)) begin
                        m_phase = 1; m_idx = int'(sel_idx); e_disp = 1'b1;
                    end else begin
                        e_err = 1'b1;
                    end
                end else if (coin_valid) begin
                    if (m_credit + int'(coin_value) > 255) e_rej = 1'b1;
                    else m_credit = m_credit + int'(coin_value);
                end
            end else if (m_phase == 1) begin
                e_rej = coin_valid;
                m_credit = m_credit - prices[m_idx];
                if (STOCK_EN) m_stock[m_idx] = m_stock[m_idx] - 1;
                m_phase = (m_credit > 0) ? 2 : 0;
            end else begin
                e_rej = coin_valid;
                if (change_ack) begin
                    m_credit = 0; m_phase = 0;
                end
            end
            if (STOCK_EN && restock) m_stock[restock_idx] = 1;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!reset) begin
            chk("credit", int'(credit), m_credit);
            chk("avail", int'(avail), int'(exp_avail()));
            chk("busy", int'(busy), int'(m_phase != 0));
            chk("dispense", int'(dispense), int'(e_disp));
            if (e_disp) chk("dispense_idx", int'(dispense_idx), m_idx);
            chk("change_valid", int'(change_valid), int'(m_phase == 2));
            if (m_phase == 2) chk("change_amt", int'(change_amt), m_credit);
            chk("coin_reject", int'(coin_reject), int'(e_rej));
            chk("sel_err", int'(sel_err), int'(e_err));
        end
    end

    task automatic tick(input bit cv, input int val, input bit sv, input int idx,
                        input bit cn, input bit ack);
        coin_valid = cv;
        coin_value = 8'(val);
        sel_valid  = sv;
        sel_idx    = 2'(idx);
        cancel     = cn;
        change_ack = ack;
        @(posedge clk);
        #1;
        coin_valid = 1'b0; coin_value = 8'd0; sel_valid = 1'b0; sel_idx = 2'd0;
        cancel = 1'b0; change_ack = 1'b0; restock = 1'b0; restock_idx = 2'd0;
    endtask

    task automatic coin(input int v);  tick(1'b1, v, 1'b0, 0, 1'b0, 1'b0); endtask
    task automatic sel(input int i);   tick(1'b0, 0, 1'b1, i, 1'b0, 1'b0); endtask
    task automatic idle();             tick(1'b0, 0, 1'b0, 0, 1'b0, 1'b0); endtask
    task automatic ack();              tick(1'b0, 0, 1'b0, 0, 1'b0, 1'b1); endtask
    task automatic cncl();             tick(1'b0, 0, 1'b0, 0, 1'b1, 1'b0); endtask

    initial begin
        n_vec = 0; n_err = 0;
        coin_valid = 1'b0; coin_value = 8'd0; sel_valid = 1'b0; sel_idx = 2'd0;
        cancel = 1'b0; change_ack = 1'b0; restock = 1'b0; restock_idx = 2'd0;
        reset = 1'b1;
        #2;
        chk("rst_credit", int'(credit), 0);
        chk("rst_avail", int'(avail), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_change_valid", int'(change_valid), 0);
        chk("rst_change_amt", int'(change_amt), 0);
        chk("rst_dispense", int'(dispense), 0);
        chk("rst_dispense_idx", int'(dispense_idx), 0);
        chk("rst_coin_reject", int'(coin_reject), 0);
        chk("rst_sel_err", int'(sel_err), 0);
        #10 reset = 1'b0;
        @(posedge clk); #1;

        // Exact-price purchase of product 3.
        coin(10); coin(5); coin(10);
        chk("t1_credit", int'(credit), 25);
        chk("t1_avail", int'(avail), 15);
        sel(3);
        chk("t1_dispense", int'(dispense), 1);
        chk("t1_dispense_idx", int'(dispense_idx), 3);
        idle();
        chk("t1_credit_after", int'(credit), 0);
        chk("t1_no_change", int'(change_valid), 0);
        chk("t1_busy_after", int'(busy), 0);

        // Purchase with change, coin bounced while paying out.
        coin(10); coin(10); coin(10);
        sel(1);
        chk("t2_dispense_idx", int'(dispense_idx), 1);
        idle();
        chk("t2_change_valid", int'(change_valid), 1);
        chk("t2_change_amt", int'(change_amt), 15);
        coin(5);
        chk("t2_busy_reject", int'(coin_reject), 1);
        idle();
        chk("t2_amt_held", int'(change_amt), 15);
        ack();
        chk("t2_credit_after", int'(credit), 0);
        chk("t2_cv_after", int'(change_valid), 0);

        // Overflow boundary.
        coin(100); coin(100); coin(50);
        chk("t3_credit250", int'(credit), 250);
        coin(10);
        chk("t3_reject", int'(coin_reject), 1);
        chk("t3_credit_kept", int'(credit), 250);
        coin(5);
        chk("t3_credit255", int'(credit), 255);
        chk("t3_no_reject", int'(coin_reject), 0);
        coin(0);
        chk("t3_zero_coin", int'(credit), 255);
        cncl();
        chk("t3_refund_amt", int'(change_amt), 255);
        ack();

        // Refused selection, then three-way collision.
        coin(10);
        sel(2);
        chk("t4_sel_err", int'(sel_err), 1);
        chk("t4_credit_kept", int'(credit), 10);
        tick(1'b1, 5, 1'b1, 0, 1'b1, 1'b0);
        chk("t4_refund_cv", int'(change_valid), 1);
        chk("t4_refund_amt", int'(change_amt), 10);
        chk("t4_coin_reject", int'(coin_reject), 1);
        chk("t4_no_sel_err", int'(sel_err), 0);
        sel(0);
        chk("t4_busy_sel_ignored", int'(sel_err), 0);
        ack();

        // Asynchronous reset during payout.
        coin(20);
        cncl();
        chk("t5_amt20", int'(change_amt), 20);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_cv", int'(change_valid), 0);
        chk("t5_async_credit", int'(credit), 0);
        #3 reset = 1'b0;
        @(posedge clk); #1;

`ifdef VEND_STOCK_EN
        // Stock exhaustion and restock (STOCK_INIT = 1).
        coin(10);
        sel(0);
        idle();
        coin(20);
        chk("t6_avail_empty", int'(avail), 6);
        sel(0);
        chk("t6_sel_err", int'(sel_err), 1);
        restock = 1'b1; restock_idx = 2'd0;
        idle();
        chk("t6_avail_restocked", int'(avail), 7);
        sel(0);
        restock = 1'b1; restock_idx = 2'd0;
        idle();
        chk("t6_change", int'(change_amt), 10);
        ack();
        coin(10);
        chk("t6_restock_wins", int'(avail), 1);
`endif
        idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
